i2d_if: RTL and testbench

Instruction fetch stage of the i2d pipeline, directly upstream of the decode stage. Holds the fetch PC and issues one-at-a-time requests to instruction memory. Buffers returned words in a small prefetch FIFO and presents one registered {instruction, PC, bubble flag} triple per cycle on `if_ins`/`if_pc`/`if_dis`. Honours downstream stall and flush-and-redirect from decode/branch/SWI/exception logic.

---
 rtl/i2d_if_pkg.sv | 25 ++
 rtl/i2d_if_fifo.sv | 74 +++++++
 rtl/i2d_if.sv | 163 ++++++++++++++++
 tb/tb_i2d_if.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2d_if_pkg.sv
// Shared constants and types for the i2d instruction fetch stage.
package i2d_if_pkg;

    localparam int unsigned INS_W        = 32;
    localparam logic [31:0] I2D_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DROP = 2'b10
    } fetch_st_e;

    typedef struct packed {
        logic [31:0]      pc;
        logic [INS_W-1:0] ins;
    } fetch_ent_t;

    localparam fetch_ent_t ENT_ZERO = '{pc: 32'h0000_0000, ins: 32'h0000_0000};

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/i2d_if_fifo.sv
// Prefetch FIFO holding {pc, ins} entries between instruction memory and decode.
module i2d_if_fifo
    import i2d_if_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  fetch_ent_t              wdata,
    output fetch_ent_t              rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_ent_t         mem_q [DEPTH];
    fetch_ent_t         mem_d [DEPTH];
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    // Next-state for storage, pointers and occupancy; flush wins over push/pop.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = {AW{1'b0}};
            rptr_d = {AW{1'b0}};
            cnt_d  = {CW{1'b0}};
        end else begin
            if (push) begin
                mem_d[wptr_q] = wdata;
                wptr_d        = wptr_q + AW'(1'b1);
            end else begin
                wptr_d = wptr_q;
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1'b1);
            end else begin
                rptr_d = rptr_q;
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= ENT_ZERO;
            end
            wptr_q <= {AW{1'b0}};
            rptr_q <= {AW{1'b0}};
            cnt_q  <= {CW{1'b0}};
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign count = cnt_q;
    assign empty = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/i2d_if.sv
// i2d fetch stage: fetch FSM, fetch PC and registered {ins, pc, bubble} output to decode.
module i2d_if
    import i2d_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = I2D_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             im_req,
    output logic [31:0]      im_addr,
    input  logic             im_ack,
    input  logic [31:0]      im_rdata,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [INS_W-1:0] if_ins,
    output logic [31:0]      if_pc,
    output logic             if_dis
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    fetch_st_e        st_q, st_d;
    logic [31:0]      fpc_q, fpc_d;
    logic [31:0]      addr_q, addr_d;
    logic             req_q, req_d;
    logic [INS_W-1:0] ins_q, ins_d;
    logic [31:0]      pc_q, pc_d;
    logic             dis_q, dis_d;

    logic             busy_ack_s;
    logic             fifo_push_s;
    logic             fifo_pop_s;
    logic             fifo_empty_s;
    logic [CW-1:0]    fifo_cnt_s;
    logic [CW-1:0]    cnt_nxt_s;
    logic             slot_free_s;
    logic [31:0]      tgt_s;
    fetch_ent_t       fifo_head_s;
    fetch_ent_t       fifo_wdata_s;

    i2d_if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .flush (redirect),
        .wdata (fifo_wdata_s),
        .rdata (fifo_head_s),
        .count (fifo_cnt_s),
        .empty (fifo_empty_s)
    );

    // A request may only be (re)issued if the FIFO will still have room next cycle,
    // so an ack taken under stall always has a slot to land in.
    always_comb begin
        tgt_s        = word_align(redirect_pc);
        busy_ack_s   = (st_q == ST_BUSY) && im_ack;
        fifo_push_s  = busy_ack_s && !redirect && (stall || !fifo_empty_s);
        fifo_pop_s   = !redirect && !stall && !fifo_empty_s;
        fifo_wdata_s = '{pc: fpc_q, ins: im_rdata};
        if (redirect) begin
            cnt_nxt_s = {CW{1'b0}};
        end else begin
            cnt_nxt_s = fifo_cnt_s + CW'(fifo_push_s) - CW'(fifo_pop_s);
        end
        slot_free_s = (cnt_nxt_s < FULL_CNT);
    end

    // Fetch FSM, fetch PC and output register next-state.
    always_comb begin
        st_d   = st_q;
        fpc_d  = fpc_q;
        ins_d  = ins_q;
        pc_d   = pc_q;
        dis_d  = dis_q;

        case (st_q)
            ST_IDLE: begin
                if (redirect) begin
                    fpc_d = tgt_s;
                    st_d  = ST_BUSY;
                end else if (slot_free_s) begin
                    st_d = ST_BUSY;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (redirect) begin
                    fpc_d = tgt_s;
                    st_d  = im_ack ? ST_BUSY : ST_DROP;
                end else if (im_ack) begin
                    fpc_d = fpc_q + PC_STEP;
                    st_d  = slot_free_s ? ST_BUSY : ST_IDLE;
                end else begin
                    st_d = ST_BUSY;
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    fpc_d = tgt_s;
                end else begin
                    fpc_d = fpc_q;
                end
                st_d = im_ack ? ST_BUSY : ST_DROP;
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase

        // DROP keeps presenting the abandoned address until its ack arrives.
        addr_d = (st_d == ST_BUSY) ? fpc_d : addr_q;
        req_d  = (st_d != ST_IDLE);

        if (redirect) begin
            dis_d = 1'b1;
        end else if (stall) begin
            dis_d = dis_q;
        end else if (!fifo_empty_s) begin
            ins_d = fifo_head_s.ins;
            pc_d  = fifo_head_s.pc;
            dis_d = 1'b0;
        end else if (busy_ack_s) begin
            ins_d = im_rdata;
            pc_d  = fpc_q;
            dis_d = 1'b0;
        end else begin
            dis_d = 1'b1;
        end
    end

    // All fetch-stage state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= ST_IDLE;
            fpc_q  <= RESET_PC;
            addr_q <= RESET_PC;
            req_q  <= 1'b0;
            ins_q  <= {INS_W{1'b0}};
            pc_q   <= 32'h0000_0000;
            dis_q  <= 1'b1;
        end else begin
            st_q   <= st_d;
            fpc_q  <= fpc_d;
            addr_q <= addr_d;
            req_q  <= req_d;
            ins_q  <= ins_d;
            pc_q   <= pc_d;
            dis_q  <= dis_d;
        end
    end

    assign im_req  = req_q;
    assign im_addr = addr_q;
    assign if_ins  = ins_q;
    assign if_pc   = pc_q;
    assign if_dis  = dis_q;

endmodule

// File: tb/tb_i2d_if.sv
// Bench for i2d_if: memory responder, scoreboard of the expected decode stream, directed and random phases.
module tb_i2d_if;

    localparam logic [31:0] KEY    = 32'hA5A5_0000;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_ins;
    logic [31:0] if_pc;
    logic        if_dis;

    int          n_chk = 0;
    int          n_pass = 0;
    int          consumed = 0;
    int          wait_mode = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic        mem_busy = 1'b0;
    int          mem_wcnt = 0;
    int          mem_age = 0;
    logic [31:0] mem_req_addr = 32'h0000_0000;

    always #5 clk = ~clk;

    i2d_if #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ack      (im_ack),
        .im_rdata    (im_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_ins      (if_ins),
        .if_pc       (if_pc),
        .if_dis      (if_dis)
    );

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Expected decode stream after a (re)start: consecutive words from the aligned target.
    task automatic restart(input logic [31:0] pc);
        logic [31:0] p;
        p = pc & 32'hFFFF_FFFC;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back({p, p ^ KEY});
            p = p + 32'd4;
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    // Memory: one request at a time, programmable wait, data = addr ^ KEY.
    always @(negedge clk) begin
        if (!rst) begin
            im_ack   = 1'b0;
            mem_busy = 1'b0;
        end else begin
            if (im_ack) mem_busy = 1'b0;
            if (im_req) begin
                if (!mem_busy) begin
                    mem_busy     = 1'b1;
                    mem_req_addr = im_addr;
                    mem_age      = 0;
                    mem_wcnt     = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
                end else begin
                    mem_age++;
                    check(im_addr == mem_req_addr, "im_addr_stable", im_addr, mem_req_addr);
                end
                if (mem_wcnt == 0) begin
                    im_ack   = 1'b1;
                    im_rdata = mem_req_addr ^ KEY;
                end else begin
                    im_ack   = 1'b0;
                    im_rdata = $urandom;
                    mem_wcnt--;
                end
            end else begin
                im_ack   = 1'b0;
                im_rdata = $urandom;
                mem_busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor: decode takes the presented word when it is valid, not stalled, not flushed.
    always @(negedge clk) begin
        #2;
        if (rst && !redirect && !stall && !if_dis) begin
            consumed++;
            if (exp_q.size() == 0) begin
                check(1'b0, "exp_underflow", if_pc, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check(if_pc == mon_e[63:32], "if_pc", if_pc, mon_e[63:32]);
                check(if_ins == mon_e[31:0], "if_ins", if_ins, mon_e[31:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] prev, hold_pc, hold_ins, old_addr;
        int          acks;
        bit          found;

        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        im_ack = 1'b0; im_rdata = 32'h0;

        // Reset values and first fetch.
        step; step;
        check(if_ins == 32'h0, "rst_if_ins", if_ins, 32'h0);
        check(if_pc == 32'h0, "rst_if_pc", if_pc, 32'h0);
        check(if_dis == 1'b1, "rst_if_dis", {31'h0, if_dis}, 32'h1);
        check(im_req == 1'b0, "rst_im_req", {31'h0, im_req}, 32'h0);
        check(im_addr == RST_PC, "rst_im_addr", im_addr, RST_PC);
        restart(RST_PC);
        rst = 1'b1;
        step;
        check(im_req == 1'b1, "edge1_im_req", {31'h0, im_req}, 32'h1);
        check(im_addr == RST_PC, "edge1_im_addr", im_addr, RST_PC);
        check(if_dis == 1'b1, "edge1_if_dis", {31'h0, if_dis}, 32'h1);
        step;
        check(if_dis == 1'b0, "edge2_if_dis", {31'h0, if_dis}, 32'h0);
        check(if_pc == RST_PC, "edge2_if_pc", if_pc, RST_PC);
        check(if_ins == (RST_PC ^ KEY), "edge2_if_ins", if_ins, RST_PC ^ KEY);
        prev = im_addr;
        for (int i = 0; i < 8; i++) begin
            step;
            check(im_addr == prev + 32'd4, "seq_im_addr", im_addr, prev + 32'd4);
            check(if_dis == 1'b0, "seq_if_dis", {31'h0, if_dis}, 32'h0);
            prev = im_addr;
        end

        // Stall for 5 cycles: outputs frozen, two acks fill the FIFO, then im_req drops.
        stall    = 1'b1;
        hold_pc  = if_pc;
        hold_ins = if_ins;
        acks     = int'(im_ack);
        for (int i = 1; i <= 5; i++) begin
            step;
            if (i == 5) stall = 1'b0;
            check(if_pc == hold_pc, "stall_if_pc", if_pc, hold_pc);
            check(if_ins == hold_ins, "stall_if_ins", if_ins, hold_ins);
            if (i < 5) acks += int'(im_ack);
            if (i == 4) check(im_req == 1'b0, "stall_im_req", {31'h0, im_req}, 32'h0);
        end
        check(acks == 2, "stall_acks", acks, 32'd2);
        for (int i = 0; i < 4; i++) begin
            step;
            check(if_dis == 1'b0, "unstall_no_gap", {31'h0, if_dis}, 32'h0);
        end

        // 3-wait memory with a redirect to 0x100 in the second wait cycle.
        wait_mode = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step;
            if (mem_busy && mem_age == 1 && !im_ack) found = 1'b1;
        end
        check(found, "drop_sync", {31'h0, found}, 32'h1);
        if (found) begin
            old_addr    = im_addr;
            redirect    = 1'b1;
            redirect_pc = 32'h0000_0100;
            restart(32'h0000_0100);
            step;
            redirect = 1'b0;
            check(if_dis == 1'b1, "drop_if_dis", {31'h0, if_dis}, 32'h1);
            check(im_addr == old_addr, "drop_old_addr", im_addr, old_addr);
            found = 1'b0;
            for (int i = 0; i < 10 && !found; i++) begin
                if (im_ack) found = 1'b1;
                else step;
            end
            check(found, "drop_ack_seen", {31'h0, found}, 32'h1);
            step;
            check(im_req == 1'b1 && im_addr == 32'h0000_0100, "drop_new_addr", im_addr, 32'h0000_0100);
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                if (!if_dis) found = 1'b1;
                else step;
            end
            check(found && if_pc == 32'h0000_0100, "drop_first_pc", if_pc, 32'h0000_0100);
        end

        // Redirect to an unaligned target while stalled.
        wait_mode   = -1;
        step;
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        restart(32'h0000_0203);
        step;
        redirect = 1'b0;
        check(if_dis == 1'b1, "stall_redir_dis", {31'h0, if_dis}, 32'h1);
        step; step;
        stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step;
            if (!if_dis) found = 1'b1;
        end
        check(found && if_pc == 32'h0000_0200, "stall_redir_pc", if_pc, 32'h0000_0200);

        // Fetch PC wrap-around with zero-wait memory.
        wait_mode = 0;
        for (int i = 0; i < 6; i++) step;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        restart(32'hFFFF_FFF8);
        step;
        redirect = 1'b0;
        check(im_addr == 32'hFFFF_FFF8, "wrap_addr0", im_addr, 32'hFFFF_FFF8);
        step;
        check(im_addr == 32'hFFFF_FFFC, "wrap_addr1", im_addr, 32'hFFFF_FFFC);
        check(if_pc == 32'hFFFF_FFF8, "wrap_pc0", if_pc, 32'hFFFF_FFF8);
        step;
        check(im_addr == 32'h0000_0000, "wrap_addr2", im_addr, 32'h0000_0000);
        check(if_pc == 32'hFFFF_FFFC, "wrap_pc1", if_pc, 32'hFFFF_FFFC);
        step;
        check(if_pc == 32'h0000_0000, "wrap_pc2", if_pc, 32'h0000_0000);

        // Random stall, wait and redirect traffic.
        wait_mode = -1;
        for (int i = 0; i < 600; i++) begin
            step;
            stall = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 19) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
                restart(redirect_pc);
            end else begin
                redirect = 1'b0;
            end
        end
        step;
        stall    = 1'b0;
        redirect = 1'b0;

        // Reset while a request is outstanding.
        wait_mode = 3;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step;
            if (im_req && !im_ack) found = 1'b1;
        end
        check(found, "rst_req_sync", {31'h0, found}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check(im_req == 1'b0, "arst_im_req", {31'h0, im_req}, 32'h0);
        check(if_dis == 1'b1, "arst_if_dis", {31'h0, if_dis}, 32'h1);
        check(if_pc == 32'h0 && if_ins == 32'h0, "arst_if_pc_ins", if_pc, 32'h0);
        check(im_addr == RST_PC, "arst_im_addr", im_addr, RST_PC);
        step;
        wait_mode = 0;
        restart(RST_PC);
        rst = 1'b1;
        step;
        check(im_req == 1'b1 && im_addr == RST_PC, "rel1_im_addr", im_addr, RST_PC);

        // Reset with the FIFO full.
        for (int i = 0; i < 4; i++) step;
        stall = 1'b1;
        step; step; step;
        check(im_req == 1'b0, "full_im_req", {31'h0, im_req}, 32'h0);
        rst = 1'b0;
        #1;
        check(if_dis == 1'b1, "frst_if_dis", {31'h0, if_dis}, 32'h1);
        check(if_pc == 32'h0 && if_ins == 32'h0, "frst_if_pc_ins", if_pc, 32'h0);
        check(im_addr == RST_PC && im_req == 1'b0, "frst_im", im_addr, RST_PC);
        step;
        stall = 1'b0;
        restart(RST_PC);
        rst = 1'b1;
        step;
        check(im_req == 1'b1 && im_addr == RST_PC, "rel2_im_addr", im_addr, RST_PC);
        step;
        check(if_dis == 1'b0 && if_pc == RST_PC, "rel2_if_pc", if_pc, RST_PC);
        for (int i = 0; i < 20; i++) step;

        check(consumed > 100, "consumed_count", consumed, 32'd100);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
